// File: rtl/pt2262_pkg.sv
// Shared trit codes, PT2262 timing constants and the trit-select helper.
// One alpha unit equals one clk cycle.
package pt2262_pkg;

   typedef enum logic [1:0] {
      TRIT_0 = 2'b00,
      TRIT_1 = 2'b01,
      TRIT_F = 2'b10,
      TRIT_X = 2'b11
   } trit_t;

   localparam int unsigned N_TRITS   = 12;
   localparam int unsigned CB_LEN    = 32;
   localparam int unsigned SB_LEN    = 128;
   localparam int unsigned NARROW    = 4;
   localparam int unsigned WIDE      = 12;
   localparam int unsigned FRAME_LEN = 512;

   // Trit 0 sits in the MSBs; indices past trit 11 read as invalid so they stay silent.
   function automatic trit_t get_trit(input logic [23:0] word, input logic [3:0] idx);
      trit_t t;
      case (idx)
         4'd0:    t = trit_t'(word[23:22]);
         4'd1:    t = trit_t'(word[21:20]);
         4'd2:    t = trit_t'(word[19:18]);
         4'd3:    t = trit_t'(word[17:16]);
         4'd4:    t = trit_t'(word[15:14]);
         4'd5:    t = trit_t'(word[13:12]);
         4'd6:    t = trit_t'(word[11:10]);
         4'd7:    t = trit_t'(word[9:8]);
         4'd8:    t = trit_t'(word[7:6]);
         4'd9:    t = trit_t'(word[5:4]);
         4'd10:   t = trit_t'(word[3:2]);
         4'd11:   t = trit_t'(word[1:0]);
         default: t = TRIT_X;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/pt2262_enc_cb_gen.sv
// Code-bit shaper: free-running 5-bit phase counter and the
// combinational PT2262 code-bit waveform for the selected trit.
module cb_gen
   import pt2262_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [1:0] state,
   output logic       q
);

   localparam logic [3:0] NARROW_P = 4'(NARROW);
   localparam logic [3:0] WIDE_P   = 4'(WIDE);

   logic [4:0] phase_r;
   logic       narrow_s;
   logic       wide_s;
   logic       q_s;

   // Phase counter, held at zero while clr is asserted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_r <= 5'd0;
      end else if (clr) begin
         phase_r <= 5'd0;
      end else begin
         phase_r <= phase_r + 5'd1;
      end
   end

   // Each code bit is two 16-cycle halves, each starting with a narrow or wide pulse.
   always_comb begin
      narrow_s = (phase_r[3:0] < NARROW_P);
      wide_s   = (phase_r[3:0] < WIDE_P);
      q_s      = 1'b0;
      case (trit_t'(state))
         TRIT_0:  q_s = narrow_s;
         TRIT_1:  q_s = wide_s;
         TRIT_F: begin
            if (phase_r[4]) begin
               q_s = wide_s;
            end else begin
               q_s = narrow_s;
            end
         end
         default: q_s = 1'b0;
      endcase
   end

   assign q = q_s;

endmodule

// File: rtl/pt2262_enc_sb_gen.sv
// Sync-bit shaper: 7-bit phase counter, output high for the first NARROW phases.
module sb_gen
   import pt2262_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic q
);

   localparam logic [6:0] NARROW_P = 7'(NARROW);

   logic [6:0] phase_r;

   // Phase counter; it wraps every 128 cycles so it lines up with frame cycle 384.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_r <= 7'd0;
      end else if (clr) begin
         phase_r <= 7'd0;
      end else begin
         phase_r <= phase_r + 7'd1;
      end
   end

   assign q = (phase_r < NARROW_P);

endmodule

// File: rtl/pt2262_enc.sv
// PT2262-compatible encoder: shadow word, frame counter, code/sync mux
// and registered q / eof outputs.
module pt2262_enc
   import pt2262_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ld,
   input  logic [23:0] ad,
   output logic        q,
   output logic        eof
);

   localparam logic [8:0] SYNC_START = 9'(N_TRITS * CB_LEN);
   localparam logic [8:0] LAST_CYCLE = 9'(FRAME_LEN - 1);

   logic [23:0] shadow_r;
   logic [23:0] shadow_nxt_s;
   logic [8:0]  cnt_r;
   logic [8:0]  cnt_nxt_s;
   logic        q_r;
   logic        q_nxt_s;
   logic        eof_r;
   logic        eof_nxt_s;
   logic        clr_s;
   trit_t       trit_s;
   logic        cb_q_s;
   logic        sb_q_s;

   assign clr_s  = ld;
   assign trit_s = get_trit(shadow_r, cnt_r[8:5]);

   cb_gen u_cb_gen (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_s),
      .state (trit_s),
      .q     (cb_q_s)
   );

   sb_gen u_sb_gen (
      .clk (clk),
      .rst (rst),
      .clr (clr_s),
      .q   (sb_q_s)
   );

   // Next-state: load/hold while ld, otherwise emit the shape for the current cycle.
   always_comb begin
      shadow_nxt_s = shadow_r;
      cnt_nxt_s    = cnt_r;
      q_nxt_s      = 1'b0;
      eof_nxt_s    = 1'b0;
      if (ld) begin
         shadow_nxt_s = ad;
         cnt_nxt_s    = 9'd0;
      end else begin
         // 9-bit counter wraps 511 -> 0 on its own
         cnt_nxt_s = cnt_r + 9'd1;
         eof_nxt_s = (cnt_r == LAST_CYCLE);
         if (cnt_r >= SYNC_START) begin
            q_nxt_s = sb_q_s;
         end else begin
            q_nxt_s = cb_q_s;
         end
      end
   end

   // Frame state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_r <= 24'd0;
         cnt_r    <= 9'd0;
         q_r      <= 1'b0;
         eof_r    <= 1'b0;
      end else begin
         shadow_r <= shadow_nxt_s;
         cnt_r    <= cnt_nxt_s;
         q_r      <= q_nxt_s;
         eof_r    <= eof_nxt_s;
      end
   end

   assign q   = q_r;
   assign eof = eof_r;

endmodule

// File: tb/tb_pt2262_enc.sv
// Self-checking bench for pt2262_enc: directed scenarios plus random words,
// compared every cycle against a frame-position reference model.
module tb_pt2262_enc;

   logic        clk;
   logic        rst;
   logic        ld;
   logic [23:0] ad;
   logic        q;
   logic        eof;

   int          n_tests;
   int          n_fail;
   int          hi_cnt;
   int          eof_cnt;
   int          inv_hi;
   int          m_pos;
   int          shown_pos;
   logic [23:0] m_shadow;
   logic        exp_q;
   logic        exp_eof;

   pt2262_enc dut (
      .clk (clk),
      .rst (rst),
      .ld  (ld),
      .ad  (ad),
      .q   (q),
      .eof (eof)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Waveform value at frame position k (0..511) for word w.
   function automatic logic ref_q(input logic [23:0] w, input int k);
      int          p;
      logic [23:0] sh;
      logic [1:0]  tr;
      if (k >= 384) return ((k - 384) < 4);
      p  = k % 32;
      sh = w >> (22 - 2 * (k / 32));
      tr = sh[1:0];
      case (tr)
         2'b00:   return (p <= 3) || (p >= 16 && p <= 19);
         2'b01:   return (p <= 11) || (p >= 16 && p <= 27);
         2'b10:   return (p <= 3) || (p >= 16 && p <= 27);
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b (pos %0d)", tag, obs, expv, shown_pos);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock: drive inputs, advance the model, check q and eof after the edge.
   task automatic cycle(input logic l, input logic [23:0] a);
      ld = l;
      ad = a;
      @(posedge clk);
      if (l) begin
         m_shadow  = a;
         m_pos     = 0;
         exp_q     = 1'b0;
         exp_eof   = 1'b0;
         shown_pos = -1;
      end else begin
         exp_q     = ref_q(m_shadow, m_pos);
         exp_eof   = (m_pos == 511);
         shown_pos = m_pos;
         m_pos     = (m_pos + 1) % 512;
      end
      #1;
      check_bit("q", q, exp_q);
      check_bit("eof", eof, exp_eof);
      if (q) hi_cnt++;
      if (eof) eof_cnt++;
      if (q && shown_pos >= 96 && shown_pos <= 127) inv_hi++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 24'($urandom()));
   endtask

   logic [23:0] word;
   logic [23:0] word_b;

   initial begin
      n_tests = 0; n_fail = 0; hi_cnt = 0; eof_cnt = 0; inv_hi = 0;
      m_pos = 0; shown_pos = -1; m_shadow = 24'd0;
      rst = 1'b0; ld = 1'b0; ad = 24'd0;

      // reset state
      #3;
      check_bit("rst_q", q, 1'b0);
      check_bit("rst_eof", eof, 1'b0);
      #19;
      rst = 1'b1;

      // all-'0' word after reset release: 100 high cycles, one eof
      hi_cnt = 0; eof_cnt = 0;
      run(512);
      check_int("zero_word_hi", hi_cnt, 100);
      check_int("zero_word_eof", eof_cnt, 1);

      // asynchronous reset mid-frame while q is high
      run(2);
      check_bit("pre_rst_q", q, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check_bit("async_rst_q", q, 1'b0);
      check_bit("async_rst_eof", eof, 1'b0);
      m_shadow = 24'd0; m_pos = 0;
      #2;
      rst = 1'b1;
      run(40);

      // test-plan word, ld for two cycles
      word = 24'b000100000001010101001010;
      cycle(1'b1, word);
      cycle(1'b1, word);
      hi_cnt = 0; eof_cnt = 0;
      cycle(1'b0, 24'd0);
      check_bit("first_edge_q", q, 1'b1);
      run(511);
      check_int("word_hi_f1", hi_cnt, 196);
      check_int("word_eof_f1", eof_cnt, 1);
      hi_cnt = 0; eof_cnt = 0;
      run(512);
      check_int("word_hi_f2", hi_cnt, 196);
      check_int("word_eof_f2", eof_cnt, 1);

      // uniform '0', '1', 'F' words, single-cycle ld
      cycle(1'b1, 24'h000000); run(70);
      cycle(1'b1, 24'h555555); run(70);
      cycle(1'b1, 24'hAAAAAA); run(70);

      // abort at trit 5 with a new word
      word   = 24'h5A1284;
      word_b = 24'h09A455;
      cycle(1'b1, word);
      run(5 * 32 + 7);
      cycle(1'b1, word_b);
      check_bit("abort_q", q, 1'b0);
      run(600);

      // invalid trit at position 3
      word = 24'h482912;
      word[17:16] = 2'b11;
      cycle(1'b1, word);
      inv_hi = 0;
      run(512);
      check_int("invalid_trit_hi", inv_hi, 0);

      // random words with random ld pulses
      for (int r = 0; r < 6; r++) begin
         cycle(1'b1, 24'($urandom()));
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) cycle(1'b1, 24'($urandom()));
            else cycle(1'b0, 24'($urandom()));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
